// File: rtl/axi_burst_memory_slave.sv
// AXI4 burst memory slave: word-addressed array of MEM_DEPTH entries behind
// independent write (AW/W/B) and read (AR/R) state machines. FIXED and INCR
// bursts of 32-bit beats are supported. Any other burst type or size is answered
// with SLVERR, and the array is not touched for that burst.
module axi_burst_memory_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                    clk,
  input  logic                    resetn,
  // write address
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  // write data
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  // write response
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  // read address
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  // read data
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  // write channel context
  w_state_t            r_wstate;
  logic [ID_WIDTH-1:0] r_w_id;
  logic [IDX_W-1:0]    r_w_idx;
  logic [7:0]          r_w_len;
  logic [7:0]          r_w_beat;
  logic                r_w_fixed;
  logic                r_w_err;
  logic                r_w_over;

  // read channel context
  r_state_t            r_rstate;
  logic [IDX_W-1:0]    r_r_idx;
  logic [7:0]          r_r_len;
  logic [7:0]          r_r_beat;
  logic                r_r_fixed;
  logic                r_r_err;

  logic [IDX_W-1:0]    w_aw_idx;
  logic [IDX_W-1:0]    w_ar_idx;
  logic [IDX_W-1:0]    w_r_idx_nxt;
  logic                w_aw_err;
  logic                w_ar_err;
  logic                w_mem_we;
  logic                w_unused;

  assign w_aw_idx    = awaddr[2 +: IDX_W];
  assign w_ar_idx    = araddr[2 +: IDX_W];
  assign w_aw_err    = awburst[1] || (awsize != 3'b010);
  assign w_ar_err    = arburst[1] || (arsize != 3'b010);
  assign w_r_idx_nxt = r_r_fixed ? r_r_idx : r_r_idx + 1'b1;
  assign w_mem_we    = resetn && (r_wstate == W_DATA) && wvalid && !r_w_err;
  // Address bits outside the word index are deliberately ignored.
  assign w_unused    = &{1'b0, awaddr[ADDR_WIDTH-1:IDX_W+2], awaddr[1:0],
                         araddr[ADDR_WIDTH-1:IDX_W+2], araddr[1:0]};

  // Byte-lane merge of every accepted, non-errored write beat into the array.
  // NOTE: the array has no reset branch so it maps onto RAM; its contents survive resetn.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) r_mem[r_w_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Write FSM: AW accept, W beats until wlast, then hold B until bready.
  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wstate  <= W_IDLE;
      awready   <= 1'b0;
      wready    <= 1'b0;
      bvalid    <= 1'b0;
      bresp     <= RESP_OKAY;
      bid       <= '0;
      r_w_id    <= '0;
      r_w_idx   <= '0;
      r_w_len   <= '0;
      r_w_beat  <= '0;
      r_w_fixed <= 1'b0;
      r_w_err   <= 1'b0;
      r_w_over  <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (awready && awvalid) begin
            r_w_id    <= awid;
            r_w_idx   <= w_aw_idx;
            r_w_len   <= awlen;
            r_w_beat  <= '0;
            r_w_fixed <= (awburst == 2'b00);
            r_w_err   <= w_aw_err;
            r_w_over  <= 1'b0;
            awready   <= 1'b0;
            wready    <= 1'b1;
            r_wstate  <= W_DATA;
          end else begin
            awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (wvalid) begin
            if (wlast) begin
              wready   <= 1'b0;
              bvalid   <= 1'b1;
              bid      <= r_w_id;
              bresp    <= (r_w_err || r_w_over || (r_w_beat != r_w_len)) ? RESP_SLVERR : RESP_OKAY;
              r_wstate <= W_RESP;
            end else begin
              // Beats past awlen are still accepted; the overrun is remembered for bresp.
              if (r_w_beat == r_w_len) r_w_over <= 1'b1;
              r_w_beat <= r_w_beat + 8'd1;
              if (!r_w_fixed) r_w_idx <= r_w_idx + 1'b1;
            end
          end
        end
        default: begin
          if (bready) begin
            bvalid   <= 1'b0;
            awready  <= 1'b1;
            r_wstate <= W_IDLE;
          end
        end
      endcase
    end
  end

  // Read FSM: AR accept, then one registered R beat per handshake until rlast.
  // Array reads here see pre-edge contents, giving read-before-write ordering.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rstate  <= R_IDLE;
      arready   <= 1'b0;
      rvalid    <= 1'b0;
      rlast     <= 1'b0;
      rdata     <= '0;
      rresp     <= RESP_OKAY;
      rid       <= '0;
      r_r_idx   <= '0;
      r_r_len   <= '0;
      r_r_beat  <= '0;
      r_r_fixed <= 1'b0;
      r_r_err   <= 1'b0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (arready && arvalid) begin
            r_r_idx   <= w_ar_idx;
            r_r_len   <= arlen;
            r_r_beat  <= '0;
            r_r_fixed <= (arburst == 2'b00);
            r_r_err   <= w_ar_err;
            arready   <= 1'b0;
            rvalid    <= 1'b1;
            rid       <= arid;
            rresp     <= w_ar_err ? RESP_SLVERR : RESP_OKAY;
            rdata     <= w_ar_err ? '0 : r_mem[w_ar_idx];
            rlast     <= (arlen == 8'd0);
            r_rstate  <= R_DATA;
          end else begin
            arready <= 1'b1;
          end
        end
        default: begin
          if (rready) begin
            if (rlast) begin
              rvalid   <= 1'b0;
              rlast    <= 1'b0;
              arready  <= 1'b1;
              r_rstate <= R_IDLE;
            end else begin
              r_r_beat <= r_r_beat + 8'd1;
              r_r_idx  <= w_r_idx_nxt;
              rdata    <= r_r_err ? '0 : r_mem[w_r_idx_nxt];
              rlast    <= ((r_r_beat + 8'd1) == r_r_len);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/axi_burst_memory_slave.md
# axi_burst_memory_slave

AXI4 burst-capable memory slave that sits directly downstream of the AXI memory burst master. It accepts AW/W/B and AR/R transactions from the master and stores data in an internal word-addressed array of MEM_DEPTH entries. It also serves as the behavioural-plus-synthesizable memory model for master-level simulation. Write and read channels run independent state machines and may be active concurrently.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data bus width; only 32 is supported
- ID_WIDTH, 4, transaction ID width
- MEM_DEPTH, 256, number of DATA_WIDTH words; must be a power of two
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- awid/awaddr/awlen/awsize/awburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  write address
- awvalid  in  1  write address valid; awready  out  1
- wdata/wstrb/wlast  in  DATA_WIDTH/DATA_WIDTH/8/1  write data
- wvalid  in  1  write data valid; wready  out  1
- bid/bresp  out  ID_WIDTH/2  write response; bvalid  out  1; bready  in  1
- arid/araddr/arlen/arsize/arburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  read address
- arvalid  in  1  read address valid; arready  out  1
- rid/rdata/rresp/rlast  out  ID_WIDTH/DATA_WIDTH/2/1  read data
- rvalid  out  1  read data valid; rready  in  1

## Operation
- Word index: addr[2 +: log2(MEM_DEPTH)]. Higher address bits are ignored, so the index wraps modulo MEM_DEPTH.
- Supported bursts:
  - FIXED (00): index held constant for all beats.
  - INCR (01): index increments by 1 per beat, with modulo wrap.
- Errors latched at the address handshake:
  - burst 10 or 11, or size != 3'b010, gives SLVERR (2'b10).
  - Memory is not accessed for an errored burst, but all beats are still handshaked.
- Write FSM:
  - W_IDLE: awready=1. On AW handshake, latch id, index, len, burst and err; go to W_DATA.
  - W_DATA: wready=1. Each W handshake writes the bytes enabled by wstrb (byte-lane merge) and advances the index.
  - When wlast is seen, go to W_RESP. If wlast arrives on a beat count != awlen, bresp=SLVERR; the burst still ends at wlast.
  - If beat count reaches awlen without wlast, keep accepting beats until wlast; bresp=SLVERR.
  - W_RESP: bvalid=1, bid=latched id. Hold until bready, then go to W_IDLE.
- Read FSM:
  - R_IDLE: arready=1. On AR handshake, latch fields; go to R_DATA.
  - R_DATA: rvalid=1, rdata=mem[index] (0 if err), rresp=OKAY or SLVERR, rid=latched id, rlast=(beat==arlen).
  - On each R handshake, advance the index and beat counter and load the next word. After the handshake on the rlast beat, go to R_IDLE.
- Write and read hitting the same word in the same cycle: read-before-write. The R beat presents the old value, and the new value is visible on the next read.

## Timing
- Reset values:
  - awready=0, wready=0, bvalid=0, bresp=0, bid=0.
  - arready=0, rvalid=0, rlast=0, rdata=0, rresp=0, rid=0.
  - Memory contents are not cleared.
- awready and arready are registered. They rise on the first clk edge after resetn goes high, and drop in the cycle following the handshake.
- Write latency:
  - wready rises 1 cycle after the AW handshake.
  - bvalid rises 1 cycle after the wlast handshake.
  - awready returns 1 cycle after the B handshake.
- Read latency:
  - First rvalid comes 1 cycle after the AR handshake.
  - With rready held high, one beat per cycle, so an (arlen+1)-beat burst takes arlen+2 cycles from AR.
  - arready returns 1 cycle after the last R handshake.
- All outputs are registered and hold stable while valid && !ready.
- A B response is not dropped: bvalid holds through any bready stall.
- resetn low mid-burst aborts both FSMs to idle in the same edge, and all outputs take their reset values.
- awlen=0 and arlen=0 are legal single-beat bursts; rlast is 1 on the first beat.

## Test plan
- 8-beat INCR write to 0x0 with data 10..17 and wstrb=4'hF, then 8-beat INCR read from 0x0 -> rdata 10..17, rlast only on beat 8, bresp=rresp=OKAY, bid=rid=4'hA.
- Write 32'hFFFFFFFF to 0x10, then single beat 32'h12345678 with wstrb=4'b0101 -> read returns 32'hFF34FF78.
- INCR 4-beat write starting at byte 0x3F8 (word 254) -> words 254, 255, 0, 1 are written; read-back matches.
- FIXED 4-beat write of 1..4 to 0x20 -> read of 0x20 returns 4; neighbouring words are unchanged.
- 8-beat read with rready toggled 1,0,1,0 -> every beat is held stable while stalled, no data is skipped, total of 8 handshakes.
- Error cases:
  - awburst=2'b10 -> bresp=SLVERR, memory unchanged.
  - wlast on beat 3 of an awlen=7 burst -> bresp=SLVERR.
  - resetn pulsed mid-read -> rvalid=0 next cycle.
